// File: rtl/mod_chain_pkg.sv
// Shared definitions for the mod_chain elastic pipeline.
// Mode encodings travel with every beat through each stage.
package mod_chain_pkg;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_INC  = 2'b01;
  localparam logic [1:0] MODE_INV  = 2'b10;
  localparam logic [1:0] MODE_RSVD = 2'b11;

endpackage

// File: rtl/mod_chain_stage.sv
// One elastic stage: main register plus skid register, applying the beat's
// mode operation as the beat enters the stage.
module mod_chain_stage
  import mod_chain_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_in,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_out,
  output logic [1:0]       o_mode
);

  logic             r_main_valid, r_skid_valid, r_ready;
  logic [WIDTH-1:0] r_main_data, r_skid_data;
  logic [1:0]       r_main_mode, r_skid_mode;

  logic             w_main_valid_d, w_skid_valid_d;
  logic [WIDTH-1:0] w_main_data_d, w_skid_data_d, w_op;
  logic [1:0]       w_main_mode_d, w_skid_mode_d;
  logic             w_in_fire, w_out_fire;

  always_comb begin
    case (i_mode)
      MODE_INC: w_op = i_in + WIDTH'(1);
      MODE_INV: w_op = ~i_in;
      default:  w_op = i_in;
    endcase
  end

  assign w_in_fire  = i_valid && r_ready;
  assign w_out_fire = r_main_valid && i_ready;

  // r_ready mirrors an empty skid, so an accepted beat never meets a full skid.
  always_comb begin
    w_main_valid_d = r_main_valid;
    w_main_data_d  = r_main_data;
    w_main_mode_d  = r_main_mode;
    w_skid_valid_d = r_skid_valid;
    w_skid_data_d  = r_skid_data;
    w_skid_mode_d  = r_skid_mode;
    if (i_flush) begin
      w_main_valid_d = 1'b0;
      w_skid_valid_d = 1'b0;
    end else if (!r_main_valid || w_out_fire) begin
      if (r_skid_valid) begin
        w_main_valid_d = 1'b1;
        w_main_data_d  = r_skid_data;
        w_main_mode_d  = r_skid_mode;
        w_skid_valid_d = 1'b0;
      end else begin
        w_main_valid_d = w_in_fire;
        if (w_in_fire) begin
          w_main_data_d = w_op;
          w_main_mode_d = i_mode;
        end
      end
    end else if (w_in_fire) begin
      w_skid_valid_d = 1'b1;
      w_skid_data_d  = w_op;
      w_skid_mode_d  = i_mode;
    end
  end

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_main_valid <= 1'b0;
      r_main_data  <= '0;
      r_main_mode  <= '0;
      r_skid_valid <= 1'b0;
      r_skid_data  <= '0;
      r_skid_mode  <= '0;
      r_ready      <= 1'b0;
    end else begin
      r_main_valid <= w_main_valid_d;
      r_main_data  <= w_main_data_d;
      r_main_mode  <= w_main_mode_d;
      r_skid_valid <= w_skid_valid_d;
      r_skid_data  <= w_skid_data_d;
      r_skid_mode  <= w_skid_mode_d;
      r_ready      <= !w_skid_valid_d;
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_main_valid;
  assign o_out   = r_main_data;
  assign o_mode  = r_main_mode;

endmodule

// File: rtl/mod_chain.sv
// N-stage elastic processing chain with flush and a delivered-beat counter.
module mod_chain
  import mod_chain_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_STAGES = 2,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_x,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_in,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_out,
  output logic [1:0]       o_mode,
  output logic [CNT_W-1:0] o_count
);

  logic             w_valid [NUM_STAGES+1];
  logic             w_ready [NUM_STAGES+1];
  logic [WIDTH-1:0] w_data  [NUM_STAGES+1];
  logic [1:0]       w_mode  [NUM_STAGES+1];
  logic [CNT_W-1:0] r_count;

  assign w_valid[0]          = i_valid;
  assign w_data[0]           = i_in;
  assign w_mode[0]           = i_mode;
  assign w_ready[NUM_STAGES] = i_ready;

  for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
    mod_chain_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_x   (rst_x),
      .i_flush (i_flush),
      .i_valid (w_valid[g]),
      .o_ready (w_ready[g]),
      .i_mode  (w_mode[g]),
      .i_in    (w_data[g]),
      .o_valid (w_valid[g+1]),
      .i_ready (w_ready[g+1]),
      .o_out   (w_data[g+1]),
      .o_mode  (w_mode[g+1])
    );
  end

  // Output transfers are counted even on a flush cycle.
  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      r_count <= '0;
    end else if (w_valid[NUM_STAGES] && i_ready) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_ready = w_ready[0];
  assign o_valid = w_valid[NUM_STAGES];
  assign o_out   = w_data[NUM_STAGES];
  assign o_mode  = w_mode[NUM_STAGES];
  assign o_count = r_count;

endmodule

// File: tb/tb_mod_chain.sv
// Directed and randomised checks of mod_chain (2-stage, 3-stage, 4-bit counter).
module tb_mod_chain;

  localparam int W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_x;

  logic         i_flush, i_valid, o_ready, o_valid, i_ready;
  logic [1:0]   i_mode, o_mode;
  logic [W-1:0] i_in, o_out;
  logic [15:0]  o_count;

  logic         t_valid, t_ready_o, t_ovalid;
  logic [1:0]   t_mode, t_mode_o;
  logic [W-1:0] t_in, t_out;
  logic [15:0]  t_count;

  logic         c_valid, c_ready_o, c_ovalid;
  logic [1:0]   c_mode_o;
  logic [W-1:0] c_in, c_out;
  logic [3:0]   c_count;

  mod_chain #(.WIDTH(W), .NUM_STAGES(2), .CNT_W(16)) dut (
    .clk(clk), .rst_x(rst_x), .i_flush(i_flush), .i_valid(i_valid), .o_ready(o_ready),
    .i_mode(i_mode), .i_in(i_in), .o_valid(o_valid), .i_ready(i_ready), .o_out(o_out),
    .o_mode(o_mode), .o_count(o_count)
  );

  mod_chain #(.WIDTH(W), .NUM_STAGES(3), .CNT_W(16)) dut3 (
    .clk(clk), .rst_x(rst_x), .i_flush(1'b0), .i_valid(t_valid), .o_ready(t_ready_o),
    .i_mode(t_mode), .i_in(t_in), .o_valid(t_ovalid), .i_ready(1'b1), .o_out(t_out),
    .o_mode(t_mode_o), .o_count(t_count)
  );

  mod_chain #(.WIDTH(W), .NUM_STAGES(2), .CNT_W(4)) dutc (
    .clk(clk), .rst_x(rst_x), .i_flush(1'b0), .i_valid(c_valid), .o_ready(c_ready_o),
    .i_mode(2'b00), .i_in(c_in), .o_valid(c_ovalid), .i_ready(1'b1), .o_out(c_out),
    .o_mode(c_mode_o), .o_count(c_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [1:0] m, input int n);
    logic [W-1:0] r;
    r = d;
    for (int i = 0; i < n; i++) begin
      if (m == 2'b01) r = r + 1;
      else if (m == 2'b10) r = ~r;
    end
    return r;
  endfunction

  logic [W-1:0] q[$];
  logic [W-1:0] exp_d;
  int           nacc, nout, first, last, seen, xfer;
  logic         acc;

  initial begin
    rst_x = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_mode = 2'b00; i_in = '0;
    t_valid = 1'b0; t_mode = 2'b00; t_in = '0; c_valid = 1'b0; c_in = '0;

    // Reset
    repeat (3) tick();
    check("rst_valid", o_valid, 0);
    check("rst_count", o_count, 0);
    check("rst_ready", o_ready, 0);
    check("rst_out", o_out, 0);
    check("rst_mode", o_mode, 0);
    rst_x = 1'b1;
    check("rst_ready_hold", o_ready, 0);
    tick();
    check("rst_ready_rel", o_ready, 1);

    // Modes, back-to-back
    i_ready = 1'b1;
    i_valid = 1'b1; i_in = 32'h0000_0005; i_mode = 2'b01; tick();
    i_in = 32'h0000_00FF; i_mode = 2'b10; tick();
    check("mode_inc_valid", o_valid, 1);
    check("mode_inc", o_out, 32'h0000_0007);
    check("mode_inc_mode", o_mode, 2'b01);
    i_in = 32'h1234_5678; i_mode = 2'b00; tick();
    check("mode_inv", o_out, 32'h0000_00FF);
    i_valid = 1'b0; tick();
    check("mode_pass", o_out, 32'h1234_5678);
    tick();
    check("mode_idle", o_valid, 0);
    check("mode_count", o_count, 3);

    // Wrap (2-stage INC) and 3-stage INV
    i_valid = 1'b1; i_in = 32'hFFFF_FFFF; i_mode = 2'b01;
    t_valid = 1'b1; t_in = 32'h0; t_mode = 2'b10;
    tick();
    i_valid = 1'b0; t_valid = 1'b0;
    tick();
    check("wrap_valid", o_valid, 1);
    check("wrap_inc", o_out, 32'h0000_0001);
    tick();
    check("inv3_valid", t_ovalid, 1);
    check("inv3_out", t_out, 32'hFFFF_FFFF);
    check("inv3_mode", t_mode_o, 2'b10);
    repeat (2) tick();
    check("inv3_count", t_count, 1);

    // Backpressure
    i_ready = 1'b0; nacc = 0;
    for (int k = 0; k < 8; k++) begin
      i_valid = 1'b1; i_in = W'(nacc); i_mode = 2'b00; acc = o_ready;
      tick();
      if (acc) nacc++;
    end
    i_valid = 1'b0;
    check("bp_accepted", nacc, 4);
    check("bp_ready_low", o_ready, 0);
    check("bp_head_stable", o_out, 0);
    i_ready = 1'b1; nout = 0; first = -1; last = -1;
    for (int k = 0; k < 12; k++) begin
      if (o_valid) begin
        check("bp_order", o_out, nout);
        if (first < 0) first = k;
        last = k;
        nout++;
      end
      tick();
    end
    check("bp_out_count", nout, 4);
    check("bp_no_gap", last - first, 3);
    check("bp_ready_back", o_ready, 1);

    // Flush with three beats in flight
    i_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_valid = 1'b1; i_in = W'(100 + k); tick();
    end
    i_flush = 1'b1; i_valid = 1'b1; i_in = 32'hDEAD;
    tick();
    i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    check("flush_valid_next", o_valid, 0);
    seen = 0;
    repeat (5) begin
      if (o_valid) seen++;
      tick();
    end
    check("flush_no_out", seen, 0);
    check("flush_count", o_count, 8);
    i_valid = 1'b1; i_in = 32'h42; i_mode = 2'b00; tick();
    i_valid = 1'b0;
    check("flush_lat1", o_valid, 0);
    tick();
    check("flush_lat2", o_valid, 1);
    check("flush_lat2_out", o_out, 32'h42);
    tick();
    check("flush_count2", o_count, 9);

    // 4-bit counter wrap
    for (int k = 0; k < 17; k++) begin
      c_valid = 1'b1; c_in = W'(k); tick();
    end
    c_valid = 1'b0;
    repeat (4) tick();
    check("cnt_wrap", c_count, 1);
    check("cnt_last_out", c_out, 16);
    check("cnt_idle", c_ovalid, 0);
    check("cnt_mode", c_mode_o, 0);
    check("cnt_ready", c_ready_o, 1);

    // Async reset mid-stream
    i_ready = 1'b0; i_valid = 1'b1; i_in = 32'h77;
    repeat (2) tick();
    i_valid = 1'b0;
    #2 rst_x = 1'b0;
    #1;
    check("arst_valid", o_valid, 0);
    check("arst_count", o_count, 0);
    check("arst_out", o_out, 0);
    check("arst_ready", o_ready, 0);
    tick();
    rst_x = 1'b1;
    tick();

    // Random traffic against a scoreboard
    xfer = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      i_valid = 1'($urandom_range(0, 1));
      i_in    = $urandom;
      i_mode  = 2'($urandom_range(0, 3));
      i_ready = ($urandom_range(0, 3) != 0);
      if (i_valid && o_ready) q.push_back(model(i_in, i_mode, 2));
      if (o_valid && i_ready) begin
        if (q.size() == 0) check("sb_underflow", 1, 0);
        else begin
          exp_d = q.pop_front();
          check("sb_data", o_out, exp_d);
        end
        xfer++;
      end
      tick();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (o_valid) begin
        if (q.size() == 0) check("sb_underflow", 1, 0);
        else begin
          exp_d = q.pop_front();
          check("sb_data", o_out, exp_d);
        end
        xfer++;
      end
      tick();
    end
    check("sb_empty", q.size(), 0);
    check("sb_count", o_count, 16'(xfer));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
